key_matrix: RTL and testbench

- Consumes the 80-bit active-low key vector from the HPS memory-mapped register block and presents it to the emulated CPC as a 10-row × 8-column keyboard matrix.
- The PPI port C row select (bits 3:0) picks a row. The selected column byte goes to the AY I/O port A read path.
- The matrix is snapshotted on the CRTC frame sync so the Z80 scan never sees a torn update.
- A minimum-hold counter stops a short HPS press/release from being missed by the once-per-frame firmware scan.

---
 rtl/key_matrix.sv | 148 ++++++++++++++
 tb/tb_key_matrix.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix
// Description : Presents an 80-bit active-low HPS key vector to the emulated
//               CPC as a 10x8 keyboard matrix. The matrix is snapshotted on
//               each CRTC vsync rising edge. A minimum-hold counter keeps
//               short presses visible to the once-per-frame firmware scan.
//               The row is chosen through the PPI port C row latch.
// Revision    : 1.0 - initial release
// ============================================================================
module key_matrix #(
    parameter int HOLD_FRAMES = 2,
    parameter int HOLD_W      = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [79:0] keys_i,
    input  logic        vsync_i,
    input  logic        row_wr_i,
    input  logic [3:0]  row_i,
    output logic [7:0]  col_o,
    output logic [3:0]  row_o,
    output logic        update_o
);

    localparam logic [0:0]        S_IDLE    = 1'b0;
    localparam logic [0:0]        S_HOLD    = 1'b1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);
    localparam bit                HOLD_EN   = (HOLD_FRAMES > 0);

    logic [79:0]       keys_q;
    logic [79:0]       snap;
    logic              vs_prev;
    logic              vs_edge;
    logic [3:0]        row_r;
    logic [HOLD_W-1:0] hold_cnt;
    logic [0:0]        state;
    logic [0:0]        state_next;
    logic              take_snap;
    logic              dec_hold;
    logic [7:0]        row_bytes [16];

    // Input register for the key vector and previous-vsync sample for edge detection.
    // vs_prev resets high so a vsync already high at reset release is not an edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            keys_q  <= '1;
            vs_prev <= 1'b1;
        end else begin
            keys_q  <= keys_i;
            vs_prev <= vsync_i;
        end
    end

    assign vs_edge = vsync_i & ~vs_prev;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic: a fresh snapshot starts a hold period when holding is enabled.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (take_snap && HOLD_EN) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (vs_edge && (hold_cnt == HOLD_LAST)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: snapshot only from IDLE on a real change; count down edges while holding.
    always_comb begin
        take_snap = 1'b0;
        dec_hold  = 1'b0;
        case (state)
            S_IDLE:  take_snap = vs_edge && (keys_q != snap);
            S_HOLD:  dec_hold  = vs_edge;
            default: begin
                take_snap = 1'b0;
                dec_hold  = 1'b0;
            end
        endcase
    end

    // Snapshot register, hold counter and one-cycle update pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            snap     <= '1;
            hold_cnt <= '0;
            update_o <= 1'b0;
        end else begin
            update_o <= take_snap;
            if (take_snap) begin
                snap <= keys_q;
                if (HOLD_EN) begin
                    hold_cnt <= HOLD_INIT;
                end
            end else if (dec_hold) begin
                hold_cnt <= hold_cnt - HOLD_LAST;
            end
        end
    end

    // Row latch written by the PPI port C strobe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            row_r <= '0;
        end else if (row_wr_i) begin
            row_r <= row_i;
        end
    end

    assign row_o = row_r;

    // Byte view of the snapshot; rows 10..15 do not exist and read as no key pressed.
    for (genvar r = 0; r < 16; r++) begin : g_row
        if (r < 10) begin : g_live
            assign row_bytes[r] = snap[r*8 +: 8];
        end else begin : g_pad
            assign row_bytes[r] = 8'hFF;
        end
    end

    // Registered column output for the latched row.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_o <= 8'hFF;
        end else begin
            col_o <= row_bytes[row_r];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_matrix.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_matrix
// Description : Self-checking bench for key_matrix with hold of 2 and 0 frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_matrix;

    logic        clk = 1'b0;
    logic        reset;
    logic [79:0] keys;
    logic        vsync;
    logic        row_wr;
    logic [3:0]  row;
    logic [7:0]  col2, col0;
    logic [3:0]  row2, row0;
    logic        upd2, upd0;

    int checks   = 0;
    int failures = 0;

    key_matrix #(.HOLD_FRAMES(2), .HOLD_W(4)) u_dut2 (
        .clk_i(clk), .reset_i(reset), .keys_i(keys), .vsync_i(vsync),
        .row_wr_i(row_wr), .row_i(row), .col_o(col2), .row_o(row2), .update_o(upd2)
    );

    key_matrix #(.HOLD_FRAMES(0), .HOLD_W(4)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .keys_i(keys), .vsync_i(vsync),
        .row_wr_i(row_wr), .row_i(row), .col_o(col0), .row_o(row0), .update_o(upd0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] keys;
        logic [3:0]  row;
        logic [7:0]  col;
    } vec_t;

    vec_t vecs [8];

    // Reference model: index 0 holds 2 frames, index 1 holds 0 frames.
    logic [79:0] m_keysq [2];
    logic [79:0] m_snap  [2];
    logic        m_vsp   [2];
    logic [3:0]  m_row   [2];
    logic [7:0]  m_col   [2];
    logic        m_upd   [2];
    int          m_edges [2];

    logic [79:0] all_ones;
    logic [79:0] key18;
    logic        u2, u0;
    int          pulses;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        row_wr = 1'b0;
        vsync  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic vedge(output logic o2, output logic o0);
        vsync = 1'b1;
        tick();
        o2    = upd2;
        o0    = upd0;
        vsync = 1'b0;
        tick();
    endtask

    task automatic wrow(input logic [3:0] r);
        row    = r;
        row_wr = 1'b1;
        tick();
        row_wr = 1'b0;
    endtask

    // One clock of the model: a snapshot is allowed once more than HOLD
    // vsync edges have passed since the previous snapshot.
    task automatic model_step();
        int hold;
        for (int m = 0; m < 2; m++) begin
            hold = (m == 0) ? 2 : 0;
            if (reset) begin
                m_keysq[m] = '1;
                m_snap[m]  = '1;
                m_vsp[m]   = 1'b1;
                m_row[m]   = 4'd0;
                m_col[m]   = 8'hFF;
                m_upd[m]   = 1'b0;
                m_edges[m] = 1000;
            end else begin
                m_col[m] = (m_row[m] <= 4'd9) ? 8'(m_snap[m] >> (m_row[m] * 8)) : 8'hFF;
                m_upd[m] = 1'b0;
                if (vsync && !m_vsp[m]) begin
                    if (m_edges[m] < 1000) m_edges[m]++;
                    if ((m_edges[m] > hold) && (m_keysq[m] != m_snap[m])) begin
                        m_snap[m]  = m_keysq[m];
                        m_upd[m]   = 1'b1;
                        m_edges[m] = 0;
                    end
                end
                if (row_wr) m_row[m] = row;
                m_keysq[m] = keys;
                m_vsp[m]   = vsync;
            end
        end
    endtask

    initial begin
        all_ones = '1;
        key18    = all_ones & ~(80'd1 << 18);

        vecs[0] = '{keys: 80'hFFFF_FFFF_FFFF_FFFB_FFFF, row: 4'd2,  col: 8'hFB};
        vecs[1] = '{keys: 80'h0908_0706_0504_0302_0100, row: 4'd10, col: 8'hFF};
        vecs[2] = '{keys: 80'h0908_0706_0504_0302_0100, row: 4'd15, col: 8'hFF};
        vecs[3] = '{keys: 80'h0908_0706_0504_0302_0100, row: 4'd9,  col: 8'h09};
        vecs[4] = '{keys: 80'h0908_0706_0504_0302_0100, row: 4'd5,  col: 8'h05};
        vecs[5] = '{keys: 80'h0000_0000_0000_0000_0000, row: 4'd7,  col: 8'h00};
        vecs[6] = '{keys: 80'hFFFF_FFFF_FF7E_FFFF_FFFF, row: 4'd4,  col: 8'h7E};
        vecs[7] = '{keys: 80'hFFFF_FFFF_FF7E_FFFF_FFFF, row: 4'd3,  col: 8'hFF};

        // Reset with vsync held high across release: no update pulse.
        reset  = 1'b1;
        vsync  = 1'b1;
        keys   = all_ones;
        row_wr = 1'b0;
        row    = 4'd0;
        tick(); tick(); tick();
        check("rst_col", col2, 8'hFF);
        check("rst_row", row2, 4'd0);
        check("rst_upd", upd2, 1'b0);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (upd2 || upd0) pulses++;
        end
        check("vs_high_release_pulses", pulses, 0);
        vsync = 1'b0;
        tick();

        // Table-driven snapshot / row-select vectors.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            keys = vecs[i].keys;
            tick();
            vedge(u2, u0);
            wrow(vecs[i].row);
            tick();
            check($sformatf("vec%0d_col_h2", i), col2, vecs[i].col);
            check($sformatf("vec%0d_col_h0", i), col0, vecs[i].col);
        end

        // Minimum hold of 2 frames: short press held through edges 2 and 3.
        do_reset();
        keys = key18;
        tick();
        wrow(4'd2);
        vedge(u2, u0);
        check("hold_e1_upd2", u2, 1'b1);
        check("hold_e1_upd0", u0, 1'b1);
        keys = all_ones;
        tick();
        vedge(u2, u0);
        check("hold_e2_upd2", u2, 1'b0);
        check("hold_e2_upd0", u0, 1'b1);
        check("hold_e2_col2", col2, 8'hFB);
        check("hold_e2_col0", col0, 8'hFF);
        vedge(u2, u0);
        check("hold_e3_upd2", u2, 1'b0);
        check("hold_e3_upd0", u0, 1'b0);
        check("hold_e3_col2", col2, 8'hFB);
        vedge(u2, u0);
        check("hold_e4_upd2", u2, 1'b1);
        check("hold_e4_upd0", u0, 1'b0);
        check("hold_e4_single", upd2, 1'b0);
        check("hold_e4_col2", col2, 8'hFF);

        // No hold: alternating press/release is captured on every edge.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            keys = (k % 2 == 0) ? key18 : all_ones;
            tick();
            vedge(u2, u0);
            check($sformatf("nohold_e%0d_upd0", k), u0, 1'b1);
        end

        // Reset during HOLD, then immediate snapshot with simultaneous row write.
        do_reset();
        keys = key18;
        tick();
        wrow(4'd2);
        vedge(u2, u0);
        check("midhold_col_before", col2, 8'hFB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("midhold_rst_col", col2, 8'hFF);
        check("midhold_rst_row", row2, 4'd0);
        vsync  = 1'b1;
        row    = 4'd2;
        row_wr = 1'b1;
        tick();
        check("midhold_snap_upd", upd2, 1'b1);
        check("midhold_snap_row", row2, 4'd2);
        check("midhold_snap_col_old", col2, 8'hFF);
        vsync  = 1'b0;
        row_wr = 1'b0;
        tick();
        check("midhold_snap_col_new", col2, 8'hFB);

        // Randomized run against the reference model.
        for (int i = 0; i < 600; i++) begin
            reset = (i < 2) || ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 2) == 0) keys = all_ones;
                else keys = all_ones & ~(80'd1 << $urandom_range(0, 79));
            end
            if ($urandom_range(0, 2) == 0) vsync = ~vsync;
            row_wr = ($urandom_range(0, 3) == 0);
            row    = 4'($urandom_range(0, 15));
            model_step();
            tick();
            check("rnd_col_h2", col2, m_col[0]);
            check("rnd_row_h2", row2, m_row[0]);
            check("rnd_upd_h2", upd2, m_upd[0]);
            check("rnd_col_h0", col0, m_col[1]);
            check("rnd_row_h0", row0, m_row[1]);
            check("rnd_upd_h0", upd0, m_upd[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
